ddc_cic_decim: RTL and testbench

DDC_CIC_DECIM -- requirements
Module: ddc_cic_decim

---
 rtl/ddc_pkg.sv | 32 +++
 rtl/ddc_cic_lane.sv | 99 +++++++++
 rtl/ddc_cic_decim.sv | 91 +++++++++
 tb/tb_ddc_cic_decim.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ddc_pkg.sv
// rtl/ddc_pkg.sv - shared constants, types and helpers for the CIC decimator
package ddc_pkg;

    localparam int CIC_ORDER    = 3;
    localparam int CIC_MAX_LOG2 = 6;
    localparam int CIC_GROWTH   = CIC_ORDER * CIC_MAX_LOG2;

    typedef logic [2:0] decim_log2_t;

    localparam decim_log2_t DECIM_LOG2_DEFAULT = 3'd3;

    function automatic int acc_width(input int width);
        return width + CIC_GROWTH;
    endfunction

    // Only 1..6 are meaningful rates; out-of-range requests pin to the nearest end.
    function automatic decim_log2_t clamp_decim_log2(input decim_log2_t v);
        if (v == 3'd0) begin
            return 3'd1;
        end
        if (v > decim_log2_t'(CIC_MAX_LOG2)) begin
            return decim_log2_t'(CIC_MAX_LOG2);
        end
        return v;
    endfunction

    // DC gain is R^N = 2^(N*L), so the output shift is N*L bits.
    function automatic logic [4:0] scale_shift(input decim_log2_t l);
        return 5'(CIC_ORDER * int'(l));
    endfunction

endpackage

// File: rtl/ddc_cic_lane.sv
// rtl/ddc_cic_lane.sv - one CIC rail: integrators, registered combs, registered scaler
// Build option DDC_CIC_ROUND_EN selects a round-half-up + saturating scaler instead of floor.
module ddc_cic_lane
    import ddc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ACC   = acc_width(16)
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  logic [WIDTH-1:0]     i_data,
    input  logic                 i_integ_en,
    input  logic [CIC_ORDER-1:0] i_comb_en,
    input  logic                 i_out_en,
    input  logic [4:0]           i_shift,
    output logic [WIDTH-1:0]     o_data
);

    logic signed [ACC-1:0] x_ext;
    logic signed [ACC-1:0] integ1, integ2, integ3;
    logic signed [ACC-1:0] integ1_nxt, integ2_nxt, integ3_nxt;
    logic signed [ACC-1:0] comb    [CIC_ORDER];
    logic signed [ACC-1:0] dly     [CIC_ORDER];
    logic signed [ACC-1:0] comb_in [CIC_ORDER];
    logic [WIDTH-1:0]      scaled;

    assign x_ext = ACC'($signed(i_data));

    // Integrators chain combinationally so the block-completing sample feeds the first comb directly.
    always_comb begin
        integ1_nxt = integ1 + x_ext;
        integ2_nxt = integ2 + integ1_nxt;
        integ3_nxt = integ3 + integ2_nxt;
        comb_in[0] = integ3_nxt;
        for (int k = 1; k < CIC_ORDER; k++) begin
            comb_in[k] = comb[k-1];
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset || i_clear) begin
            integ1 <= '0;
            integ2 <= '0;
            integ3 <= '0;
            for (int k = 0; k < CIC_ORDER; k++) begin
                comb[k] <= '0;
                dly[k]  <= '0;
            end
        end else begin
            if (i_integ_en) begin
                integ1 <= integ1_nxt;
                integ2 <= integ2_nxt;
                integ3 <= integ3_nxt;
            end
            for (int k = 0; k < CIC_ORDER; k++) begin
                if (i_comb_en[k]) begin
                    comb[k] <= comb_in[k] - dly[k];
                    dly[k]  <= comb_in[k];
                end
            end
        end
    end

`ifdef DDC_CIC_ROUND_EN
    localparam logic signed [ACC:0] OUT_MAX = {{(ACC-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC:0] OUT_MIN = {{(ACC-WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [ACC:0] round_sum;
    logic signed [ACC:0] round_shr;

    // One guard bit keeps the half-LSB addition from wrapping near full scale.
    always_comb begin
        round_sum = {comb[CIC_ORDER-1][ACC-1], comb[CIC_ORDER-1]}
                  + ((ACC+1)'(1) << (i_shift - 5'd1));
        round_shr = round_sum >>> i_shift;
        if (round_shr > OUT_MAX) begin
            scaled = WIDTH'(OUT_MAX);
        end else if (round_shr < OUT_MIN) begin
            scaled = WIDTH'(OUT_MIN);
        end else begin
            scaled = WIDTH'(round_shr);
        end
    end
`else
    always_comb begin
        scaled = WIDTH'(comb[CIC_ORDER-1] >>> i_shift);
    end
`endif

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            o_data <= '0;
        end else if (i_out_en) begin
            o_data <= scaled;
        end
    end

endmodule

// File: rtl/ddc_cic_decim.sv
// rtl/ddc_cic_decim.sv - 3-stage I/Q CIC decimator, R = 2^L, shared rate/priming/valid control
// Build option DDC_CIC_ROUND_EN (see ddc_cic_lane) changes only the scaler arithmetic.
module ddc_cic_decim
    import ddc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_inph_data,
    input  logic [WIDTH-1:0] i_quad_data,
    input  logic             i_valid,
    input  logic [2:0]       i_decim_log2,
    input  logic             i_decim_log2_valid,
    output logic [WIDTH-1:0] o_inph_data,
    output logic [WIDTH-1:0] o_quad_data,
    output logic             o_valid
);

    localparam int ACC = acc_width(WIDTH);

    decim_log2_t             decim_log2;
    logic [CIC_MAX_LOG2-1:0] sample_cnt;
    logic [CIC_MAX_LOG2-1:0] rate_mask;
    logic [1:0]              prime_cnt;
    logic [2:1]              comb_stb;
    logic [3:1]              keep;
    logic                    rate_load;
    logic                    sample_take;
    logic                    block_done;
    logic                    primed;
    logic                    out_en;
    logic [CIC_ORDER-1:0]    comb_en;
    logic [4:0]              shift;

    assign rate_load   = i_decim_log2_valid;
    assign sample_take = i_valid && !rate_load;
    assign rate_mask   = ~({CIC_MAX_LOG2{1'b1}} << decim_log2);
    assign block_done  = sample_take && (sample_cnt == rate_mask);
    assign primed      = (prime_cnt == 2'(CIC_ORDER));
    assign comb_en     = {comb_stb[2], comb_stb[1], block_done};
    assign out_en      = keep[3] && !rate_load;
    assign shift       = scale_shift(decim_log2);

    // A rate load behaves like a reset of the datapath, except the output words are held.
    always_ff @(posedge i_clock) begin
        if (!i_reset || rate_load) begin
            decim_log2 <= !i_reset ? DECIM_LOG2_DEFAULT : clamp_decim_log2(i_decim_log2);
            sample_cnt <= '0;
            prime_cnt  <= '0;
            comb_stb   <= '0;
            keep       <= '0;
            o_valid    <= 1'b0;
        end else begin
            if (sample_take) begin
                sample_cnt <= block_done ? '0 : sample_cnt + 1'b1;
            end
            if (block_done && !primed) begin
                prime_cnt <= prime_cnt + 2'd1;
            end
            comb_stb <= {comb_stb[1], block_done};
            keep     <= {keep[2:1], block_done && primed};
            o_valid  <= keep[3];
        end
    end

    ddc_cic_lane #(.WIDTH(WIDTH), .ACC(ACC)) u_lane_inph (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_clear    (rate_load),
        .i_data     (i_inph_data),
        .i_integ_en (sample_take),
        .i_comb_en  (comb_en),
        .i_out_en   (out_en),
        .i_shift    (shift),
        .o_data     (o_inph_data)
    );

    ddc_cic_lane #(.WIDTH(WIDTH), .ACC(ACC)) u_lane_quad (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_clear    (rate_load),
        .i_data     (i_quad_data),
        .i_integ_en (sample_take),
        .i_comb_en  (comb_en),
        .i_out_en   (out_en),
        .i_shift    (shift),
        .o_data     (o_quad_data)
    );

endmodule

// File: tb/tb_ddc_cic_decim.sv
// tb/tb_ddc_cic_decim.sv - scoreboard bench for ddc_cic_decim (default and DDC_CIC_ROUND_EN builds)
module tb_ddc_cic_decim;

    localparam int WIDTH = 16;

    logic             i_clock = 1'b0;
    logic             i_reset;
    logic [WIDTH-1:0] i_inph_data;
    logic [WIDTH-1:0] i_quad_data;
    logic             i_valid;
    logic [2:0]       i_decim_log2;
    logic             i_decim_log2_valid;
    logic [WIDTH-1:0] o_inph_data;
    logic [WIDTH-1:0] o_quad_data;
    logic             o_valid;

    typedef struct {
        int due;
        int ei;
        int eq;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t drv_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   exp_i = 0;
    int   exp_q = 0;
    int   m_l = 3;
    int   m_cnt = 0;
    int   m_prime = 0;
    int   hold_i = 0;
    int   hold_q = 0;
    logic rst_q = 1'b1;
    bit   mon_en = 1'b0;

    ddc_cic_decim #(.WIDTH(WIDTH)) dut (
        .i_clock            (i_clock),
        .i_reset            (i_reset),
        .i_inph_data        (i_inph_data),
        .i_quad_data        (i_quad_data),
        .i_valid            (i_valid),
        .i_decim_log2       (i_decim_log2),
        .i_decim_log2_valid (i_decim_log2_valid),
        .o_inph_data        (o_inph_data),
        .o_quad_data        (o_quad_data),
        .o_valid            (o_valid)
    );

    always #5 i_clock = ~i_clock;

    always @(posedge i_clock) begin
        cyc   <= cyc + 1;
        rst_q <= i_reset;
    end

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge i_clock) begin
        if (mon_en) begin
            if (!rst_q) begin
                hold_i = 0;
                hold_q = 0;
            end
            if (o_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: o_valid=1 at cycle %0d, expected 0", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("valid_cycle", cyc, mon_e.due);
                    chk("out_i", $signed(o_inph_data), mon_e.ei);
                    chk("out_q", $signed(o_quad_data), mon_e.eq);
                    hold_i = mon_e.ei;
                    hold_q = mon_e.eq;
                end
            end else begin
                chk("hold_i", $signed(o_inph_data), hold_i);
                chk("hold_q", $signed(o_quad_data), hold_q);
            end
        end
    end

    // Outputs scheduled later than the current cycle are killed by a load or reset issued now.
    task automatic cancel_inflight();
        while (sb.size() > 0 && sb[$].due > cyc) begin
            void'(sb.pop_back());
        end
    endtask

    task automatic drive(input int xi, input int xq, input bit v, input bit ld, input int ldv);
        i_inph_data        = WIDTH'(xi);
        i_quad_data        = WIDTH'(xq);
        i_valid            = v;
        i_decim_log2_valid = ld;
        i_decim_log2       = 3'(ldv);
        if (ld) begin
            m_l     = (ldv == 0) ? 1 : (ldv == 7) ? 6 : ldv;
            m_cnt   = 0;
            m_prime = 0;
            cancel_inflight();
        end else if (v) begin
            if (m_cnt == (1 << m_l) - 1) begin
                m_cnt = 0;
                if (m_prime < 3) begin
                    m_prime++;
                end else begin
                    drv_e.due = cyc + 4;
                    drv_e.ei  = exp_i;
                    drv_e.eq  = exp_q;
                    sb.push_back(drv_e);
                end
            end else begin
                m_cnt++;
            end
        end
        @(posedge i_clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 1'b0, 1'b0, 0);
    endtask

    task automatic pulse_reset();
        i_reset            = 1'b0;
        i_valid            = 1'b1;
        i_inph_data        = 16'h1234;
        i_quad_data        = 16'h4321;
        i_decim_log2_valid = 1'b0;
        m_l     = 3;
        m_cnt   = 0;
        m_prime = 0;
        cancel_inflight();
        @(posedge i_clock);
        #1;
        i_reset = 1'b1;
    endtask

    int pat[10] = '{0, 0, 0, 0, 0, 2, 2, 0, 0, 0};

    initial begin
        i_reset            = 1'b0;
        i_inph_data        = '0;
        i_quad_data        = '0;
        i_valid            = 1'b0;
        i_decim_log2       = 3'd0;
        i_decim_log2_valid = 1'b0;
        repeat (2) @(posedge i_clock);
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_out_i", $signed(o_inph_data), 0);
        chk("rst_out_q", $signed(o_quad_data), 0);
        i_reset = 1'b1;
        mon_en  = 1'b1;

        // L=2, constant input, valid every cycle
        drive(0, 0, 1'b0, 1'b1, 2);
        exp_i = 1000; exp_q = -500;
        repeat (24) drive(1000, -500, 1'b1, 1'b0, 0);
        idle(8);

        // L=6 full-scale extremes
        drive(0, 0, 1'b0, 1'b1, 6);
        exp_i = -32768; exp_q = 32767;
        repeat (320) drive(-32768, 32767, 1'b1, 1'b0, 0);
        idle(6);
        drive(0, 0, 1'b0, 1'b1, 6);
        exp_i = 32767; exp_q = -32768;
        repeat (320) drive(32767, -32768, 1'b1, 1'b0, 0);
        idle(6);

        // L=1 with gaps in i_valid; data on idle cycles must be ignored
        drive(0, 0, 1'b0, 1'b1, 1);
        exp_i = 300; exp_q = -7;
        repeat (12) begin
            drive(300, -7, 1'b1, 1'b0, 0);
            drive(12345, -12345, 1'b0, 1'b0, 0);
        end
        idle(6);

        // clamp 0 -> R=2, then load 7 coincident with a sample -> R=64
        drive(0, 0, 1'b0, 1'b1, 0);
        exp_i = 50; exp_q = 60;
        repeat (14) drive(50, 60, 1'b1, 1'b0, 0);
        drive(9999, -9999, 1'b1, 1'b1, 7);
        exp_i = -77; exp_q = 11;
        repeat (320) drive(-77, 11, 1'b1, 1'b0, 0);
        idle(6);

        // mid-block reset at L=3
        drive(0, 0, 1'b0, 1'b1, 3);
        exp_i = -1234; exp_q = 4321;
        repeat (43) drive(-1234, 4321, 1'b1, 1'b0, 0);
        pulse_reset();
        chk("post_rst_valid", o_valid, 0);
        chk("post_rst_out_i", $signed(o_inph_data), 0);
        chk("post_rst_out_q", $signed(o_quad_data), 0);
        repeat (40) drive(-1234, 4321, 1'b1, 1'b0, 0);
        idle(6);

        // L=1 pattern giving comb results +/-12 then +/-2
        drive(0, 0, 1'b0, 1'b1, 1);
        for (int k = 0; k < 10; k++) begin
`ifdef DDC_CIC_ROUND_EN
            if (k == 7) begin exp_i = 2; exp_q = -1; end
            if (k == 9) begin exp_i = 0; exp_q = 0; end
`else
            if (k == 7) begin exp_i = 1; exp_q = -2; end
            if (k == 9) begin exp_i = 0; exp_q = -1; end
`endif
            drive(pat[k], -pat[k], 1'b1, 1'b0, 0);
        end
        idle(8);

        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
